// File: rtl/adc_sequencer.sv
// Channel sequencer for the AD79X8 serial ADC interface: builds control words, checks returned addresses, keeps per-channel last values.
// Define ADC_SEQ_AVG_EN to average each channel over four checked samples before emitting.
module adc_sequencer #(
    parameter int NUM_CH = 8,
    parameter bit RANGE  = 1'b0,
    parameter bit CODING = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [15:0]       adc_word,
    output logic              adc_initiate,
    input  logic              adc_cs,
    input  logic [15:0]       adc_result,
    output logic              sample_valid,
    output logic [2:0]        sample_ch,
    output logic [11:0]       sample_data,
    output logic              addr_err,
    input  logic              clr_err,
    input  logic [2:0]        rd_ch,
    output logic [11:0]       rd_data,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CAPTURE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cur_ch, exp_ch;
    logic        prime, cs_q;
    logic        take, res_ok, run_ok;
    logic        vld_p1;
    logic [2:0]  ch_p1;
    logic [11:0] data_p1;
    logic [11:0] store [NUM_CH];

    function automatic logic [15:0] ctrl_word(input logic [2:0] ch);
        return {1'b1, 1'b0, 1'b0, ch, 2'b11, 1'b0, 1'b0, RANGE, CODING, 4'b0000};
    endfunction

    function automatic logic [2:0] first_ch(input logic [NUM_CH-1:0] m);
        logic [NUM_CH-1:0] sh;
        logic [2:0]        r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            sh = m >> i;
            if (sh[0]) r = 3'(i);
        end
        return r;
    endfunction

    // Nearest enabled channel above cur, wrapping; falls back to cur itself.
    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [NUM_CH-1:0] m);
        logic [NUM_CH-1:0] sh;
        logic [2:0]        r;
        int                idx;
        r = cur;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = (int'(cur) + i) % NUM_CH;
            sh  = m >> idx;
            if (sh[0]) r = 3'(idx);
        end
        return r;
    endfunction

    assign run_ok = enable && (ch_mask != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run_ok) state_nxt = LOAD;
            LOAD:    if (!adc_cs) state_nxt = WAIT;
            WAIT:    if (!cs_q && adc_cs) state_nxt = CAPTURE;
            CAPTURE: state_nxt = run_ok ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adc_initiate = 1'b0;
        adc_word     = '0;
        busy         = 1'b1;
        case (state)
            IDLE:    busy = 1'b0;
            LOAD: begin
                adc_initiate = 1'b1;
                adc_word     = ctrl_word(cur_ch);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_ch <= '0;
            exp_ch <= '0;
            prime  <= 1'b1;
            cs_q   <= 1'b1;
        end else begin
            cs_q <= adc_cs;
            case (state)
                IDLE: if (run_ok) begin
                    prime  <= 1'b1;
                    cur_ch <= first_ch(ch_mask);
                end
                CAPTURE: begin
                    prime  <= 1'b0;
                    exp_ch <= cur_ch;
                    cur_ch <= next_ch(cur_ch, ch_mask);
                end
                default: ;
            endcase
        end
    end

    // Capture stage: the returned word belongs to the channel written one frame earlier
    assign take   = (state == CAPTURE) && !prime;
    assign res_ok = !adc_result[15] && (adc_result[14:12] == exp_ch);

`ifdef ADC_SEQ_AVG_EN
    logic [13:0] acc [NUM_CH];
    logic [1:0]  cnt [NUM_CH];

    function automatic logic [11:0] avg4(input logic [13:0] a, input logic [11:0] d);
        logic [13:0] s;
        s = a + {2'b00, d};
        return s[13:2];
    endfunction

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && run_ok)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (take && res_ok) begin
            if (cnt[exp_ch] == 2'd3) begin
                acc[exp_ch] <= '0;
                cnt[exp_ch] <= '0;
            end else begin
                acc[exp_ch] <= acc[exp_ch] + {2'b00, adc_result[11:0]};
                cnt[exp_ch] <= cnt[exp_ch] + 2'd1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            ch_p1    <= '0;
            data_p1  <= '0;
            addr_err <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < NUM_CH; i++) store[i] <= '0;
        end else begin
            vld_p1 <= 1'b0;
            if (take && !res_ok) addr_err <= 1'b1;
            else if (clr_err)    addr_err <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
            if (take && res_ok && (cnt[exp_ch] == 2'd3)) begin
                vld_p1        <= 1'b1;
                ch_p1         <= exp_ch;
                data_p1       <= avg4(acc[exp_ch], adc_result[11:0]);
                store[exp_ch] <= avg4(acc[exp_ch], adc_result[11:0]);
            end
`else
            if (take && res_ok) begin
                vld_p1        <= 1'b1;
                ch_p1         <= exp_ch;
                data_p1       <= adc_result[11:0];
                store[exp_ch] <= adc_result[11:0];
            end
`endif
            rd_data <= (int'(rd_ch) < NUM_CH) ? store[rd_ch] : '0;
        end
    end

    assign sample_valid = vld_p1;
    assign sample_ch    = ch_p1;
    assign sample_data  = data_p1;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: ADC frame model plus a list-based reference of expected words, samples and stored values.
module tb_adc_sequencer;
    localparam int NUM_CH = 8;

    logic        clk = 1'b0;
    logic        rst, enable, clr_err;
    logic [7:0]  ch_mask;
    logic [15:0] adc_word;
    logic        adc_initiate;
    logic        adc_cs = 1'b1;
    logic [15:0] adc_result = 16'h0000;
    logic        sample_valid;
    logic [2:0]  sample_ch;
    logic [11:0] sample_data;
    logic        addr_err;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic        busy;

    adc_sequencer #(.NUM_CH(NUM_CH), .RANGE(1'b0), .CODING(1'b1)) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .adc_word(adc_word), .adc_initiate(adc_initiate), .adc_cs(adc_cs),
        .adc_result(adc_result), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_data(sample_data), .addr_err(addr_err), .clr_err(clr_err),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          frames_done = 0;
    int          err_frame = 0;
    int          init_viol = 0;
    int          cnt_m = 0;
    logic [2:0]  prev_ch_m = 3'd0;
    logic [2:0]  cur_ch_m = 3'd0;
    logic [2:0]  a_m;
    logic [11:0] d_m;
    logic [15:0] sent_words[$];
    logic [11:0] ret_data[$];
    logic [11:0] data_plan[$];
    logic [14:0] got[$];
    logic [11:0] last_val[8];

    // ADC model: 16-clock frame, returns {0, channel of previous frame, data}
    always @(negedge clk) begin
        if (adc_cs) begin
            if (adc_initiate) begin
                adc_cs   = 1'b0;
                cnt_m    = 16;
                cur_ch_m = adc_word[12:10];
                sent_words.push_back(adc_word);
            end
        end else begin
            cnt_m--;
            if (cnt_m == 0) begin
                if (data_plan.size() > 0) d_m = data_plan.pop_front();
                else                      d_m = 12'($urandom);
                a_m = (err_frame != 0 && frames_done == err_frame) ? (prev_ch_m ^ 3'd3) : prev_ch_m;
                adc_result = {1'b0, a_m, d_m};
                adc_cs     = 1'b1;
                ret_data.push_back(d_m);
                prev_ch_m  = cur_ch_m;
                frames_done++;
            end
        end
    end

    always @(negedge clk) if (sample_valid) got.push_back({sample_ch, sample_data});

    always @(posedge clk) begin
        #1;
        if (!adc_cs && adc_initiate) init_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int ch);
        return 16'h8310 + 16'(ch * 1024);
    endfunction

    task automatic wait_frames(input int k);
        int c = 0;
        while (frames_done < k && c < 200 * k) begin
            @(negedge clk);
            c++;
        end
        check("frames_reached", 32'(frames_done >= k), 32'd1);
    endtask

    task automatic wait_cs(input logic level);
        int c = 0;
        while (adc_cs !== level && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("cs_level", 32'(adc_cs), 32'(level));
    endtask

    task automatic check_store();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rd_ch = 3'(c);
            @(negedge clk);
            check("store_rd", 32'(rd_data), 32'(last_val[c]));
        end
    endtask

    // Runs n frames from IDLE, drops enable midway through the last one, then checks everything.
    task automatic run_session(input logic [7:0] mask, input int n, input int errf);
        int          enabled[$];
        int          acc[8];
        int          cnt[8];
        logic [14:0] expq[$];
        int          c, ch, viol0;
        @(negedge clk);
        sent_words.delete();
        ret_data.delete();
        got.delete();
        frames_done = 0;
        err_frame   = errf;
        viol0       = init_viol;
        ch_mask     = mask;
        enable      = 1'b1;
        wait_frames(1);
        repeat (3) @(negedge clk);
        check("no_pulse_prime", 32'(got.size()), 32'd0);
        wait_frames(n - 1);
        wait_cs(1'b0);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        wait_frames(n);
        repeat (4) @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);
        c = 0;
        repeat (10) begin
            @(negedge clk);
            if (adc_initiate) c++;
        end
        check("initiate_after_stop", 32'(c), 32'd0);
        check("initiate_low_on_cs", 32'(init_viol - viol0), 32'd0);
        check("addr_err", 32'(addr_err), 32'(errf != 0));

        for (int j = 0; j < 8; j++) begin
            if (mask[j]) enabled.push_back(j);
            acc[j] = 0;
            cnt[j] = 0;
        end
        check("n_words", 32'(sent_words.size()), 32'(n));
        for (int i = 0; i < n && i < sent_words.size(); i++)
            check("word", 32'(sent_words[i]), 32'(word_of(enabled[i % enabled.size()])));
        for (int i = 1; i < n && i < ret_data.size(); i++) begin
            if (i != errf) begin
                ch = enabled[(i - 1) % enabled.size()];
`ifdef ADC_SEQ_AVG_EN
                acc[ch] += int'(ret_data[i]);
                cnt[ch]++;
                if (cnt[ch] == 4) begin
                    expq.push_back({3'(ch), 12'(acc[ch] / 4)});
                    acc[ch] = 0;
                    cnt[ch] = 0;
                end
`else
                expq.push_back({3'(ch), ret_data[i]});
`endif
            end
        end
        check("n_pulses", 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check("pulse", 32'(got[i]), 32'(expq[i]));
        for (int i = 0; i < expq.size(); i++) last_val[expq[i][14:12]] = expq[i][11:0];

        if (errf != 0) begin
            @(negedge clk);
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
            check("clr_err", 32'(addr_err), 32'd0);
        end
        check_store();
    endtask

    initial begin
        int snap;
        rst     = 1'b1;
        enable  = 1'b0;
        clr_err = 1'b0;
        ch_mask = 8'h00;
        rd_ch   = 3'd0;
        for (int i = 0; i < 8; i++) last_val[i] = 12'h000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_initiate", 32'(adc_initiate), 32'd0);
        check("rst_word", 32'(adc_word), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);

        repeat (5) data_plan.push_back(12'hABC);
        run_session(8'h21, 5, 0);

        run_session(8'h01, 4, 3);

        repeat (4) run_session(8'($urandom_range(1, 255)), $urandom_range(3, 7), 0);

        // Reset in the middle of a frame
        @(negedge clk);
        sent_words.delete();
        ret_data.delete();
        got.delete();
        frames_done = 0;
        err_frame   = 0;
        ch_mask     = 8'($urandom_range(1, 255));
        enable      = 1'b1;
        wait_frames(2);
        wait_cs(1'b0);
        repeat (5) @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_initiate", 32'(adc_initiate), 32'd0);
        check("mid_rst_word", 32'(adc_word), 32'd0);
        check("mid_rst_valid", 32'(sample_valid), 32'd0);
        check("mid_rst_ch", 32'(sample_ch), 32'd0);
        check("mid_rst_data", 32'(sample_data), 32'd0);
        check("mid_rst_addr_err", 32'(addr_err), 32'd0);
        snap = got.size();
        wait_cs(1'b1);
        repeat (4) @(negedge clk);
        check("trailing_frame_pulse", 32'(got.size()), 32'(snap));
        for (int i = 0; i < 8; i++) last_val[i] = 12'h000;
        check_store();
        run_session(8'($urandom_range(1, 255)), 4, 0);

        data_plan.push_back(12'h000);
        data_plan.push_back(12'h100);
        data_plan.push_back(12'h102);
        data_plan.push_back(12'h104);
        data_plan.push_back(12'h106);
        run_session(8'h01, 5, 0);
`ifdef ADC_SEQ_AVG_EN
        check("avg_of_four", 32'((got.size() > 0) ? got[0][11:0] : 12'hFFF), 32'h103);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=still_running expected=finished");
        $fatal(1, "simulation did not finish");
    end

endmodule
